uart_cmd_rx: RTL and testbench

UART_CMD_RX -- requirements
Module: uart_cmd_rx

---
 rtl/uart_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 32 +++
 rtl/uart_cmd_rx.sv | 156 +++++++++++++++
 tb/tb_uart_cmd_rx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, bit-timing helpers and
// default clock/baud constants.
package uart_pkg;

  localparam int unsigned DEF_CLK_FREQ = 50_000_000;
  localparam int unsigned DEF_BAUD     = 115_200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic int unsigned half_bit(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clks_per_bit(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit; both flops reset
// to RST_VAL.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic ff1_q, ff1_d;
  logic ff2_q, ff2_d;

  always_comb begin
    ff1_d = d;
    ff2_d = ff1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ff1_q <= RST_VAL;
      ff2_q <= RST_VAL;
    end else begin
      ff1_q <= ff1_d;
      ff2_q <= ff2_d;
    end
  end

  assign q = ff2_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// 8N1 UART command receiver: mid-bit sampling, holds the last good byte on cmd
// and reports bad stop bits (including line breaks) as a single frame_err.
module uart_cmd_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
  parameter int unsigned BAUD     = DEF_BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] cmd,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CLKS = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned HALF = half_bit(CLK_FREQ, BAUD);
  localparam int unsigned TW   = $clog2(CLKS + 1);

  localparam logic [TW-1:0] HALF_M1 = TW'(HALF - 1);
  localparam logic [TW-1:0] CLKS_M1 = TW'(CLKS - 1);

  logic rx_s;

  rx_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    cmd_q, cmd_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          busy_q, busy_d;
  logic [1:0]    settle_q, settle_d;
  logic          armed_q, armed_d;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  always_comb begin
    state_d     = state_q;
    timer_d     = '0;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    frame_err_d = 1'b0;

    // The synchronizer's reset value looks like an idle line; only trust rx_s
    // once both flops hold real samples, and arm start detection only after a
    // genuine high so a line held low across reset is not taken as a start.
    settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    armed_d  = armed_q | ((settle_q == 2'd2) & rx_s);

    case (state_q)
      ST_IDLE: begin
        if (armed_q && !rx_s) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (timer_q == HALF_M1) begin
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (timer_q == CLKS_M1) begin
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
            state_d   = ST_STOP;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_STOP: begin
        if (timer_q == CLKS_M1) begin
          if (rx_s) begin
            state_d     = ST_IDLE;
            cmd_d       = shift_q;
            cmd_valid_d = 1'b1;
          end else begin
            state_d     = ST_WAIT_IDLE;
            frame_err_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_WAIT_IDLE: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      settle_q    <= '0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
    end
  end

  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx: directed frames push expected pulses into a
// queue, a negedge monitor pops and checks each cmd_valid / frame_err pulse.
`timescale 1ns/1ps
module tb_uart_cmd_rx;

  localparam int CLKS = 434;
  localparam int HALF = 217;
  // rx fall -> 2 synchronizer edges -> IDLE edge (t0) -> stop sample at t0+HALF+9*CLKS
  localparam int VALID_LAT = 2 + 1 + HALF + 9 * CLKS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] cmd;
  logic       cmd_valid;
  logic       frame_err;
  logic       busy;

  uart_cmd_rx #(
    .CLK_FREQ(50_000_000),
    .BAUD    (115_200)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .cmd      (cmd),
    .cmd_valid(cmd_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tests     = 0;
  int   fails     = 0;
  int   cyc       = 0;
  int   valid_cyc = -1;
  int   fall_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (cmd_valid || frame_err)) begin
      exp_t e;
      if (cmd_valid) valid_cyc = cyc;
      if (cmd_valid && frame_err) begin
        tests++;
        fails++;
        $display("FAIL pulse_exclusive: cmd_valid=%b frame_err=%b, expected at most one high (cycle %0d)",
                 cmd_valid, frame_err, cyc);
      end else if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: cmd_valid=%b frame_err=%b cmd=0x%0h, expected no pulse (cycle %0d)",
                 cmd_valid, frame_err, cmd, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind_is_err", {31'd0, frame_err}, {31'd0, e.is_err});
        check("pulse_cmd", {24'd0, cmd}, {24'd0, e.data});
      end
    end
  end

  task automatic send_partial(input logic [9:0] fr, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      rx = fr[c / CLKS];
      @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    send_partial({stop_bit, b, 1'b0}, 10 * CLKS);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    check("reset_cmd", {24'd0, cmd}, 32'h0);
    check("reset_cmd_valid", {31'd0, cmd_valid}, 32'h0);
    check("reset_frame_err", {31'd0, frame_err}, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'h0);
    rst = 1'b0;
    idle(20);

    // single good byte with exact latency
    exp_q.push_back({1'b0, 8'h34});
    fall_cyc = cyc;
    send_byte(8'h34, 1'b1);
    idle(CLKS);
    check("valid_latency", valid_cyc - fall_cyc, VALID_LAT);
    check("cmd_held_34", {24'd0, cmd}, 32'h34);

    // back-to-back frames, no idle gap
    exp_q.push_back({1'b0, 8'h31});
    exp_q.push_back({1'b0, 8'h30});
    send_byte(8'h31, 1'b1);
    send_byte(8'h30, 1'b1);
    idle(CLKS);
    check("cmd_held_30", {24'd0, cmd}, 32'h30);

    // bad stop bit: cmd unchanged, stays in WAIT_IDLE while line is low
    exp_q.push_back({1'b1, 8'h30});
    send_byte(8'h35, 1'b0);
    repeat (2 * CLKS) @(negedge clk);
    check("wait_idle_busy", {31'd0, busy}, 32'h1);
    check("ferr_cmd_kept", {24'd0, cmd}, 32'h30);
    idle(10);
    check("wait_idle_exit", {31'd0, busy}, 32'h0);
    idle(CLKS);

    // 100-cycle glitch: rejected exactly at the half-bit sample
    fall_cyc = cyc;
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (119) @(negedge clk);
    check("glitch_busy_before_sample", {31'd0, busy}, 32'h1);
    @(negedge clk);
    check("glitch_busy_after_sample", {31'd0, busy}, 32'h0);
    idle(CLKS);
    check("glitch_cmd_kept", {24'd0, cmd}, 32'h30);

    // reset mid-frame with the line held low afterwards
    send_partial({1'b1, 8'h33, 1'b0}, 2003);
    rx = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midframe_rst_cmd", {24'd0, cmd}, 32'h0);
    check("midframe_rst_busy", {31'd0, busy}, 32'h0);
    rst = 1'b0;
    repeat (1000) @(negedge clk);
    check("no_false_start_busy", {31'd0, busy}, 32'h0);
    check("no_false_start_cmd", {24'd0, cmd}, 32'h0);
    idle(2 * CLKS);
    exp_q.push_back({1'b0, 8'h32});
    send_byte(8'h32, 1'b1);
    idle(CLKS);
    check("cmd_after_rst_32", {24'd0, cmd}, 32'h32);

    // break: 20 bit-times low gives a single frame_err
    exp_q.push_back({1'b1, 8'h32});
    rx = 1'b0;
    repeat (20 * CLKS) @(negedge clk);
    check("break_busy", {31'd0, busy}, 32'h1);
    idle(2 * CLKS);
    check("break_released", {31'd0, busy}, 32'h0);
    exp_q.push_back({1'b0, 8'h31});
    send_byte(8'h31, 1'b1);
    idle(CLKS);
    check("cmd_after_break_31", {24'd0, cmd}, 32'h31);

    idle(CLKS);
    check("scoreboard_drained", exp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
